// File: rtl/word_serializer.sv
// Word-to-slice serializer: latches one IN_W-bit word and emits it as IN_W/OUT_W
// OUT_W-bit slices with valid/ready on both sides and no bubble between words.
module word_serializer #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned IDX_W     = $clog2(IN_W / OUT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             last_out,
    output logic [IDX_W-1:0] idx_out
);

    localparam int unsigned      RATIO   = IN_W / OUT_W;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RATIO - 1);

    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_params
        $error("word_serializer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q;
    logic [IN_W-1:0]  word_q;
    logic [IDX_W-1:0] idx_nxt;
    logic             in_acc;
    logic             out_acc;

    function automatic logic [OUT_W-1:0] slice(input logic [IN_W-1:0]  w,
                                               input logic [IDX_W-1:0] k);
        int unsigned     ki;
        int unsigned     shamt;
        logic [IN_W-1:0] shifted;
        ki      = 32'(k);
        shamt   = MSB_FIRST ? (IN_W - (ki + 1) * OUT_W) : (ki * OUT_W);
        shifted = w >> shamt;
        return shifted[OUT_W-1:0];
    endfunction

    // A new word can only enter when nothing is shown or the last slice is leaving.
    assign ready_in = !valid_out || (last_out && ready_out);
    assign in_acc   = valid_in && ready_in;
    assign out_acc  = valid_out && ready_out;

    always_comb begin
        idx_nxt = idx_out + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            word_q    <= '0;
            idx_out   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_acc) begin
                        state_q   <= StSend;
                        word_q    <= data_in;
                        idx_out   <= '0;
                        data_out  <= slice(data_in, '0);
                        valid_out <= 1'b1;
                        last_out  <= 1'b0;
                    end
                end
                StSend: begin
                    if (in_acc) begin
                        // Last slice leaving while the next word arrives: restart at slice 0.
                        word_q    <= data_in;
                        idx_out   <= '0;
                        data_out  <= slice(data_in, '0);
                        valid_out <= 1'b1;
                        last_out  <= 1'b0;
                    end else if (out_acc) begin
                        if (last_out) begin
                            state_q   <= StIdle;
                            idx_out   <= '0;
                            data_out  <= '0;
                            valid_out <= 1'b0;
                            last_out  <= 1'b0;
                        end else begin
                            idx_out  <= idx_nxt;
                            data_out <= slice(word_q, idx_nxt);
                            last_out <= (idx_nxt == LastIdx);
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
